// File: rtl/dm_store_buffer_pkg.sv
// Shared types and helpers for the data-memory store buffer: geometry defaults,
// the buffered store entry, and the byte-lane merge used by forwarding.
package dm_store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int DM_AW    = 10;

  typedef struct packed {
    logic [DM_AW-1:0] addr;
    logic [31:0]      data;
    logic [3:0]       be;
  } sb_entry_t;

  // Lanes with be[i]=1 take the byte from upd, the rest keep base.
  function automatic logic [31:0] sb_merge(input logic [31:0] base,
                                           input logic [31:0] upd,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = base;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = upd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// Datapath-side store/load port of the store buffer.
interface dm_store_buffer_if
  import dm_store_buffer_pkg::*;
#(
  parameter int AW = DM_AW
);
  // Store handshake: a store transfers on a rising edge where st_valid and
  // st_ready are both 1; st_ready depends only on registered state, and the
  // requester holds st_addr/st_data/st_be stable while st_valid waits.
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [3:0]    st_be;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  modport master (
    output st_valid, st_addr, st_data, st_be, ld_req, ld_addr,
    input  st_ready, ld_data
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_be, ld_req, ld_addr,
    output st_ready, ld_data
  );

endinterface

// File: rtl/dm_store_buffer_sb_fifo.sv
// Circular store queue: entry storage, head/tail pointers and occupancy count.
// All entries are exported so the top level can forward from any of them.
module dm_store_buffer_sb_fifo
  import dm_store_buffer_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  sb_entry_t     din,
  input  logic          pop,
  output sb_entry_t     head_entry,
  output sb_entry_t     entries [DEPTH],
  output logic [PW-1:0] head_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  sb_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry contents carry no reset; validity comes from head/count alone.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= din;
  end

  assign entries    = mem;
  assign head_entry = mem[head];
  assign head_ptr   = head;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write buffer in front of the word-addressed data memory: queues stores,
// drains one per load-free cycle, and forwards pending bytes into loads.
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = DM_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  dm_store_buffer_if.slave  dp,
  output logic [AW-1:0]     dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  output logic [3:0]        dm_wbyte_enable,
  input  logic [31:0]       dm_dout,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t     din;
  sb_entry_t     head_entry;
  sb_entry_t     entries [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;

  assign dp.st_ready = ~full;
  assign empty       = fifo_empty;
  assign push        = dp.st_valid & ~full;
  // Loads own the memory port, so draining only happens in load-free cycles.
  assign pop         = ~fifo_empty & ~dp.ld_req;
  assign din         = sb_entry_t'{addr: dp.st_addr, data: dp.st_data, be: dp.st_be};

  dm_store_buffer_sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .din        (din),
    .pop        (pop),
    .head_entry (head_entry),
    .entries    (entries),
    .head_ptr   (head_ptr),
    .count      (count),
    .full       (full),
    .empty      (fifo_empty)
  );

  always_comb begin
    dm_addr         = '0;
    dm_din          = '0;
    dm_we           = 1'b0;
    dm_wbyte_enable = '0;
    if (dp.ld_req) begin
      dm_addr = dp.ld_addr;
    end else if (!fifo_empty) begin
      dm_addr         = head_entry.addr;
      dm_din          = head_entry.data;
      dm_wbyte_enable = head_entry.be;
      dm_we           = 1'b1;
    end
  end

  // Walk oldest to newest so later stores overwrite earlier ones per lane.
  always_comb begin
    fwd_data = dm_dout;
    idx      = '0;
    if (dp.ld_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_ptr + PW'(i);
        if ((CW'(i) < count) && (entries[idx].addr == dp.ld_addr)) begin
          fwd_data = sb_merge(fwd_data, entries[idx].data, entries[idx].be);
        end
      end
    end
  end

  assign dp.ld_data = fwd_data;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: behavioural memory, queue-based reference model
// and write-order scoreboard, driven by directed and randomized scenarios.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic        dm_we;
  logic [3:0]  dm_wbyte_enable;
  logic        empty;

  logic [31:0] mem_arr [1024];
  logic [31:0] sh_mem  [1024];
  st_t         pq [$];
  logic [45:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dm_store_buffer_if #(.AW(10)) dp ();

  dm_store_buffer #(.DEPTH(DEPTH), .AW(10)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dp              (dp),
    .dm_addr         (dm_addr),
    .dm_din          (dm_din),
    .dm_we           (dm_we),
    .dm_wbyte_enable (dm_wbyte_enable),
    .dm_dout         (dm_dout),
    .empty           (empty)
  );

  assign dm_dout = mem_arr[dm_addr];

  always @(posedge clk) begin
    if (dm_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_wbyte_enable[b]) mem_arr[dm_addr][8*b +: 8] <= dm_din[8*b +: 8];
      end
    end
  end

  // Memory writes must appear exactly in enqueue order.
  always @(negedge clk) begin
    logic [45:0] exp_w;
    if (rst_n && dm_we) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL sb_unexpected_write got=%h exp=none", {dm_addr, dm_din, dm_wbyte_enable});
      end else begin
        exp_w = exp_q.pop_front();
        if ({dm_addr, dm_din, dm_wbyte_enable} !== exp_w) begin
          bad = bad + 1;
          $display("FAIL sb_write_order got=%h exp=%h", {dm_addr, dm_din, dm_wbyte_enable}, exp_w);
        end
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [9:0] a);
    logic [31:0] w;
    w = sh_mem[a];
    foreach (pq[k]) begin
      if (pq[k].a == a) begin
        for (int b = 0; b < 4; b++) if (pq[k].be[b]) w[8*b +: 8] = pq[k].d[8*b +: 8];
      end
    end
    return w;
  endfunction

  task automatic drive(input logic sv, input logic [9:0] sa, input logic [31:0] sd,
                       input logic [3:0] sbe, input logic lr, input logic [9:0] la);
    dp.st_valid = sv;
    dp.st_addr  = sa;
    dp.st_data  = sd;
    dp.st_be    = sbe;
    dp.ld_req   = lr;
    dp.ld_addr  = la;
    #1;
  endtask

  task automatic tick();
    logic drn;
    logic enq;
    st_t  e;
    drn = rst_n && (pq.size() != 0) && !dp.ld_req;
    enq = rst_n && dp.st_valid && (pq.size() != DEPTH);
    @(posedge clk);
    if (drn) begin
      e = pq.pop_front();
      for (int b = 0; b < 4; b++) if (e.be[b]) sh_mem[e.a][8*b +: 8] = e.d[8*b +: 8];
    end
    if (enq) begin
      e.a  = dp.st_addr;
      e.d  = dp.st_data;
      e.be = dp.st_be;
      pq.push_back(e);
      exp_q.push_back({e.a, e.d, e.be});
    end
    #1;
  endtask

  task automatic drain_all(input string tag);
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    for (int c = 0; c < 3 * DEPTH && pq.size() != 0; c++) tick();
    total = total + 1;
    if (empty !== 1'b1 || exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL %s_drain got empty=%0b pending=%0d exp empty=1 pending=0", tag, empty, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    #2;
    total = total + 3;
    if (dp.st_ready !== 1'b1) begin bad++; $display("FAIL reset_st_ready got=%0b exp=1", dp.st_ready); end
    if (empty !== 1'b1)       begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    if (dm_we !== 1'b0)       begin bad++; $display("FAIL reset_dm_we got=%0b exp=0", dm_we); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    total = total + 2;
    if (dm_addr !== 10'h0) begin bad++; $display("FAIL idle_dm_addr got=%h exp=000", dm_addr); end
    if (empty !== 1'b1)    begin bad++; $display("FAIL idle_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_single_drain();
    drive(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 1'b0, '0);
    total = total + 2;
    if (dp.st_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0b exp=1", dp.st_ready); end
    if (dm_we !== 1'b0)       begin bad++; $display("FAIL single_we_early got=%0b exp=0", dm_we); end
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    total = total + 3;
    if (dm_we !== 1'b1)           begin bad++; $display("FAIL single_we got=%0b exp=1", dm_we); end
    if (dm_addr !== 10'h010)      begin bad++; $display("FAIL single_addr got=%h exp=010", dm_addr); end
    if (dm_din !== 32'hDEADBEEF)  begin bad++; $display("FAIL single_din got=%h exp=deadbeef", dm_din); end
    tick();
    total = total + 2;
    if (empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%0b exp=1", empty); end
    if (mem_arr[10'h010] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_mem got=%h exp=deadbeef", mem_arr[10'h010]);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 10'(i), $urandom, 4'hF, 1'b1, 10'h3FF);
      tick();
    end
    drive(1'b1, 10'h005, 32'h55555555, 4'hF, 1'b1, 10'h3FF);
    total = total + 3;
    if (dp.st_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0b exp=0", dp.st_ready); end
    if (dm_we !== 1'b0)       begin bad++; $display("FAIL fill_we got=%0b exp=0", dm_we); end
    if (empty !== 1'b0)       begin bad++; $display("FAIL fill_empty got=%0b exp=0", empty); end
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    total = total + 2;
    if (dm_we !== 1'b1)      begin bad++; $display("FAIL fill_drain_we got=%0b exp=1", dm_we); end
    if (dm_addr !== 10'h001) begin bad++; $display("FAIL fill_drain_addr got=%h exp=001", dm_addr); end
    tick();
    total = total + 1;
    if (dp.st_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_after got=%0b exp=1", dp.st_ready); end
    drain_all("fill");
  endtask

  task automatic test_merge();
    mem_arr[10'h020] = 32'h11223344;
    sh_mem[10'h020]  = 32'h11223344;
    drive(1'b1, 10'h020, 32'h0000AAAA, 4'b0011, 1'b1, 10'h3FF);
    tick();
    drive(1'b1, 10'h020, 32'h00BB0000, 4'b0100, 1'b1, 10'h3FF);
    tick();
    drive(1'b0, '0, '0, '0, 1'b1, 10'h020);
    total = total + 2;
    if (dp.ld_data !== 32'h11BBAAAA) begin bad++; $display("FAIL merge_ld got=%h exp=11bbaaaa", dp.ld_data); end
    if (dm_addr !== 10'h020)         begin bad++; $display("FAIL merge_addr got=%h exp=020", dm_addr); end
    tick();
    drain_all("merge");
  endtask

  task automatic test_newest();
    drive(1'b1, 10'h030, 32'h00000001, 4'hF, 1'b1, 10'h3FF);
    tick();
    drive(1'b1, 10'h030, 32'h00000002, 4'hF, 1'b1, 10'h3FF);
    tick();
    drive(1'b0, '0, '0, '0, 1'b1, 10'h030);
    total = total + 2;
    if (dp.ld_data !== 32'h00000002) begin bad++; $display("FAIL newest_ld got=%h exp=00000002", dp.ld_data); end
    if (dm_we !== 1'b0)              begin bad++; $display("FAIL newest_we got=%0b exp=0", dm_we); end
    tick();
    drain_all("newest");
    total = total + 1;
    if (mem_arr[10'h030] !== 32'h00000002) begin
      bad++; $display("FAIL newest_mem got=%h exp=00000002", mem_arr[10'h030]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10'h010, $urandom, 4'hF, 1'b1, 10'h3FF);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    total = total + 3;
    if (empty !== 1'b1)       begin bad++; $display("FAIL rstmid_empty got=%0b exp=1", empty); end
    if (dp.st_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b exp=1", dp.st_ready); end
    if (dm_we !== 1'b0)       begin bad++; $display("FAIL rstmid_we got=%0b exp=0", dm_we); end
    pq.delete();
    exp_q.delete();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    tick();
    rst_n = 1'b1;
    #1;
    total = total + 2;
    if (empty !== 1'b1) begin bad++; $display("FAIL rstrel_empty got=%0b exp=1", empty); end
    if (dm_we !== 1'b0) begin bad++; $display("FAIL rstrel_we got=%0b exp=0", dm_we); end
    tick(); tick();
    total = total + 1;
    if (mem_arr[10'h010] !== sh_mem[10'h010]) begin
      bad++; $display("FAIL rstmid_mem got=%h exp=%h", mem_arr[10'h010], sh_mem[10'h010]);
    end
  endtask

  task automatic test_back_to_back();
    logic        sv;
    logic        lr;
    logic [9:0]  la;
    int          errs;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 10'h100 + 10'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)), 1'b1, 10'h3FF);
      tick();
    end
    drive(1'b1, 10'h100 + 10'($urandom_range(0, 3)), $urandom, 4'hF, 1'b0, '0);
    total = total + 2;
    if (dm_we !== 1'b1)       begin bad++; $display("FAIL b2b_we got=%0b exp=1", dm_we); end
    if (dp.st_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", dp.st_ready); end
    tick();
    total = total + 1;
    if (empty !== 1'b0 || pq.size() != 2) begin
      bad++; $display("FAIL b2b_count got empty=%0b model=%0d exp empty=0 model=2", empty, pq.size());
    end
    for (int c = 0; c < 40; c++) begin
      sv = 1'($urandom_range(0, 1));
      lr = ($urandom_range(0, 3) == 0);
      la = 10'h100 + 10'($urandom_range(0, 3));
      drive(sv, 10'h100 + 10'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)), lr, la);
      total = total + 3;
      if (dp.st_ready !== (pq.size() != DEPTH)) begin
        bad++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, dp.st_ready, pq.size() != DEPTH);
      end
      if (empty !== (pq.size() == 0)) begin
        bad++; $display("FAIL rnd_empty c=%0d got=%0b exp=%0b", c, empty, pq.size() == 0);
      end
      if (dm_we !== (pq.size() != 0 && !lr)) begin
        bad++; $display("FAIL rnd_we c=%0d got=%0b exp=%0b", c, dm_we, pq.size() != 0 && !lr);
      end
      if (lr) begin
        total = total + 1;
        if (dp.ld_data !== ref_load(la)) begin
          bad++; $display("FAIL rnd_ld c=%0d addr=%h got=%h exp=%h", c, la, dp.ld_data, ref_load(la));
        end
      end
      tick();
    end
    drain_all("rnd");
    errs = 0;
    for (int a = 0; a < 1024; a++) if (mem_arr[a] !== sh_mem[a]) errs++;
    total = total + 1;
    if (errs != 0) begin bad++; $display("FAIL rnd_mem got=%0d differing words exp=0", errs); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 1024; a++) begin
      mem_arr[a] = $urandom;
      sh_mem[a]  = mem_arr[a];
    end
    test_reset();
    test_single_drain();
    test_fill();
    test_merge();
    test_newest();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
